// File: rtl/seg_scan_controller.sv
// -----------------------------------------------------------------------------
// seg_scan_controller
//
// Time-multiplexes a single 7448-style BCD-to-7-segment decoder across
// NUM_DIGITS common-cathode digits. Digits are scanned LSB-first (digit 0 is
// the rightmost). Between two lit digits all digit enables are dropped for
// GAP_CYCLES clocks so the decoder output can settle without ghosting onto the
// neighbouring digit.
//
// The displayed value is double-buffered. A load strobe parks digits_in in a
// pending register, which is promoted to the display register only at the
// frame wrap. A displayed frame therefore never mixes old and new digits.
//
// Leading-zero blanking is computed from the display register and presented to
// the decoder through its ripple-blank input (RBI). Lamp-test and blank-all
// requests are forwarded to the decoder's LT and BI inputs.
//
// All outputs are decoded purely from registers. The override and blanking
// inputs (lz_en, lamp_test, blank_all) are registered first, so they act one
// clock after they are applied.
//
// Handshake: load is a single-cycle strobe with no back-pressure. A strobe is
// accepted in every cycle that rst is low. It is ignored while rst is high.
// frame_done is a single-cycle pulse with no acknowledge.
//
// Ports
//   clk          in   system clock; all state changes on the rising edge
//   rst          in   synchronous reset, active-high
//   digits_in    in   4*NUM_DIGITS BCD digits; digit i = digits_in[4i+3:4i]
//   load         in   1-cycle strobe that captures digits_in
//   lz_en        in   1 = blank leading zeros
//   lamp_test    in   1 = light all segments (decoder LT)
//   blank_all    in   1 = display dark
//   dec_data     out  BCD code of the digit currently selected
//   dec_LT       out  decoder lamp test
//   dec_RBI      out  decoder ripple-blank input (a zero code shows dark)
//   dec_BI       out  decoder blank, 1 = extinguish
//   digit_en     out  one-hot digit enable, active-high; all 0 during a gap
//   frame_done   out  1-cycle pulse after each frame wrap
//   o_dbg_state  out  current scan FSM state (0 = GAP, 1 = DRIVE)
// -----------------------------------------------------------------------------
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int DRIVE_CYCLES = 49000,
  parameter int GAP_CYCLES   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    lz_en,
  input  logic                    lamp_test,
  input  logic                    blank_all,
  output logic [3:0]              dec_data,
  output logic                    dec_LT,
  output logic                    dec_RBI,
  output logic                    dec_BI,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done,
  output logic                    o_dbg_state
);

  localparam int IDX_W   = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (DRIVE_CYCLES > GAP_CYCLES) ? DRIVE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_GAP   = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                    r_state;
  logic [IDX_W-1:0]          r_idx;
  logic [CNT_W-1:0]          r_cnt;
  logic [4*NUM_DIGITS-1:0]   r_disp;
  logic [4*NUM_DIGITS-1:0]   r_pend;
  logic                      r_pend_flag;
  logic                      r_frame_done;
  logic                      r_lz;
  logic                      r_lt;
  logic                      r_ba;

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  state_t                    w_state_nxt;
  logic [IDX_W-1:0]          w_idx_nxt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic                      w_wrap;

  // ---------------------------------------------------------------------------
  // Decode wires
  // ---------------------------------------------------------------------------
  logic [3:0]                w_digit;
  logic [NUM_DIGITS-1:0]     w_onehot;
  logic [NUM_DIGITS-1:0]     w_lz_mask;
  logic                      w_upper_zero;
  logic                      w_cur_blanked;

  assign o_dbg_state = r_state;
  assign frame_done  = r_frame_done;

  // ---------------------------------------------------------------------------
  // Scan FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_wrap      = 1'b0;
    case (r_state)
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = '0;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == DRIVE_LAST) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
          if (r_idx == IDX_LAST) begin
            // The last digit has finished, so the frame wraps here.
            w_idx_nxt = '0;
            w_wrap    = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_GAP;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan FSM, buffers and registered override inputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_GAP;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pend_flag  <= 1'b0;
      r_frame_done <= 1'b0;
      r_lz         <= 1'b0;
      r_lt         <= 1'b0;
      r_ba         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_frame_done <= w_wrap;
      r_lz         <= lz_en;
      r_lt         <= lamp_test;
      r_ba         <= blank_all;

      if (w_wrap) begin
        // A load on the wrap edge bypasses the pending buffer, so the new
        // value is used in the frame that starts now.
        if (load) begin
          r_disp <= digits_in;
        end else if (r_pend_flag) begin
          r_disp <= r_pend;
        end
        r_pend_flag <= 1'b0;
      end else if (load) begin
        // Later loads in the same frame overwrite earlier ones.
        r_pend      <= digits_in;
        r_pend_flag <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select, one-hot enable and leading-zero mask
  // ---------------------------------------------------------------------------
  always_comb begin
    w_digit       = 4'h0;
    w_onehot      = '0;
    w_lz_mask     = '0;
    w_upper_zero  = 1'b1;
    w_cur_blanked = 1'b0;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_digit     = r_disp[4*i +: 4];
        w_onehot[i] = 1'b1;
      end
    end

    // Walk from the most significant digit down. A digit is a leading zero
    // while every digit from it upward is zero. Digit 0 always shows.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_upper_zero = w_upper_zero & (r_disp[4*i +: 4] == 4'h0);
      w_lz_mask[i] = r_lz & w_upper_zero & (i != 0);
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_blanked = w_lz_mask[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (from registers only)
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_data = w_digit;
    digit_en = '0;
    dec_BI   = 1'b1;
    dec_LT   = 1'b0;
    dec_RBI  = 1'b0;
    if (r_state == ST_DRIVE) begin
      if (r_ba) begin
        // blank_all wins over lamp_test. The scan keeps running underneath.
        digit_en = '0;
        dec_BI   = 1'b1;
        dec_LT   = 1'b0;
        dec_RBI  = w_cur_blanked;
      end else if (r_lt) begin
        digit_en = w_onehot;
        dec_BI   = 1'b0;
        dec_LT   = 1'b1;
        dec_RBI  = 1'b0;
      end else begin
        digit_en = w_onehot;
        dec_BI   = 1'b0;
        dec_LT   = 1'b0;
        dec_RBI  = w_cur_blanked;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// -----------------------------------------------------------------------------
// Bench for seg_scan_controller with NUM_DIGITS=4, DRIVE_CYCLES=4 and
// GAP_CYCLES=2.
//
// The reference model tracks time as a count of clocks since reset. Each frame
// is split into equal slots of gap followed by drive. The position inside the
// frame gives the digit slot and whether the digits are lit. Inputs are driven
// on the falling edge. The model consumes them at the rising edge, and all
// outputs are compared on the next falling edge.
// -----------------------------------------------------------------------------
module tb_seg_scan_controller;

  localparam int N     = 4;
  localparam int DRV   = 4;
  localparam int GAP   = 2;
  localparam int SLOT  = DRV + GAP;
  localparam int FRAME = N * SLOT;

  // ---------------------------------------------------------------------------
  // Clock / DUT
  // ---------------------------------------------------------------------------
  logic           clk;
  logic           rst;
  logic [4*N-1:0] digits_in;
  logic           load;
  logic           lz_en;
  logic           lamp_test;
  logic           blank_all;
  logic [3:0]     dec_data;
  logic           dec_LT;
  logic           dec_RBI;
  logic           dec_BI;
  logic [N-1:0]   digit_en;
  logic           frame_done;
  logic           dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  seg_scan_controller #(
    .NUM_DIGITS  (N),
    .DRIVE_CYCLES(DRV),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .load       (load),
    .lz_en      (lz_en),
    .lamp_test  (lamp_test),
    .blank_all  (blank_all),
    .dec_data   (dec_data),
    .dec_LT     (dec_LT),
    .dec_RBI    (dec_RBI),
    .dec_BI     (dec_BI),
    .digit_en   (digit_en),
    .frame_done (frame_done),
    .o_dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  int             m_t;
  logic [4*N-1:0] m_disp;
  logic [4*N-1:0] m_pend;
  bit             m_pflag;
  bit             m_lt, m_ba, m_lz, m_fd;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, m_t, obs, exp);
    end
  endtask

  // Apply one rising edge's worth of behaviour to the model.
  task automatic model_edge();
    bit wrap;
    if (rst) begin
      m_t     = 0;
      m_disp  = '0;
      m_pend  = '0;
      m_pflag = 1'b0;
      m_lt    = 1'b0;
      m_ba    = 1'b0;
      m_lz    = 1'b0;
      m_fd    = 1'b0;
    end else begin
      wrap = ((m_t % FRAME) == FRAME - 1);
      m_t++;
      m_fd = wrap;
      if (wrap) begin
        if (load) m_disp = digits_in;
        else if (m_pflag) m_disp = m_pend;
        m_pflag = 1'b0;
      end else if (load) begin
        m_pend  = digits_in;
        m_pflag = 1'b1;
      end
      m_lt = lamp_test;
      m_ba = blank_all;
      m_lz = lz_en;
    end
  endtask

  task automatic check_all();
    int p, slot;
    bit lit, blanked;
    logic [3:0]   e_data;
    logic [N-1:0] e_en;
    bit e_bi, e_lt, e_rbi;
    p       = m_t % FRAME;
    slot    = p / SLOT;
    lit     = (p % SLOT) >= GAP;
    e_data  = 4'((m_disp >> (4 * slot)) & 16'hF);
    blanked = m_lz && (slot >= 1) && ((m_disp >> (4 * slot)) == 0);
    e_en    = '0;
    e_bi    = 1'b1;
    e_lt    = 1'b0;
    e_rbi   = 1'b0;
    if (lit) begin
      if (m_ba) begin
        e_rbi = blanked;
      end else if (m_lt) begin
        e_en  = N'(1 << slot);
        e_bi  = 1'b0;
        e_lt  = 1'b1;
      end else begin
        e_en  = N'(1 << slot);
        e_bi  = 1'b0;
        e_rbi = blanked;
      end
    end
    chk("digit_en",   32'(digit_en),   32'(e_en));
    chk("dec_data",   32'(dec_data),   32'(e_data));
    chk("dec_BI",     32'(dec_BI),     32'(e_bi));
    chk("dec_LT",     32'(dec_LT),     32'(e_lt));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    // RBI is left unchecked under blank_all because the display is dark then.
    if (!(lit && m_ba)) chk("dec_RBI", 32'(dec_RBI), 32'(e_rbi));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Advance until the model is at the given frame position (bounded).
  task automatic goto_pos(input int pos);
    for (int k = 0; k < FRAME && (m_t % FRAME) != pos; k++) tick();
  endtask

  task automatic do_load(input logic [4*N-1:0] v);
    digits_in = v;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  function automatic logic [4*N-1:0] rand_value();
    logic [4*N-1:0] v;
    for (int i = 0; i < N; i++)
      v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    digits_in = 16'hFFFF;
    load      = 1'b1;
    lz_en     = 1'b0;
    lamp_test = 1'b0;
    blank_all = 1'b0;
    m_t       = 0;
    m_disp    = '0;
    m_pend    = '0;
    m_pflag   = 1'b0;
    m_lt      = 1'b0;
    m_ba      = 1'b0;
    m_lz      = 1'b0;
    m_fd      = 1'b0;

    // Reset for 3 cycles with a load strobe that must be ignored.
    run(3);
    rst  = 1'b0;
    load = 1'b0;

    // Basic scan of 1234.
    do_load(16'h1234);
    run(2 * FRAME);

    // Leading-zero blanking.
    lz_en = 1'b1;
    do_load(16'h0050);
    run(2 * FRAME);
    do_load(16'h0000);
    run(2 * FRAME);
    lz_en = 1'b0;

    // Tear-free update: a load in the digit-1 slot waits for the next frame.
    do_load(16'h1234);
    run(2 * FRAME);
    goto_pos(GAP + SLOT);
    do_load(16'h9999);
    run(FRAME + 6);

    // A load exactly on the wrap edge takes effect at once.
    goto_pos(FRAME - 1);
    do_load(16'h5678);
    run(FRAME);

    // Lamp test, then blank_all on top of it.
    lamp_test = 1'b1;
    run(FRAME);
    blank_all = 1'b1;
    run(FRAME);
    lamp_test = 1'b0;
    blank_all = 1'b0;
    run(4);

    // Reset in the middle of digit 2 with a pending load.
    do_load(16'hABCD);
    goto_pos(2 * SLOT + GAP + 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(FRAME + 4);

    // Randomised traffic.
    for (int k = 0; k < 600; k++) begin
      load      = ($urandom_range(0, 7) == 0);
      digits_in = rand_value();
      if ($urandom_range(0, 15) == 0) lz_en     = ~lz_en;
      if ($urandom_range(0, 31) == 0) lamp_test = ~lamp_test;
      if ($urandom_range(0, 31) == 0) blank_all = ~blank_all;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst  = 1'b0;
    load = 1'b0;
    run(FRAME);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
